vt52_decoder: RTL and testbench

//  Consumes the ASCII/ESC byte stream produced by the USB keyboard front-end (or host UART) via valid/ready.

---
 rtl/vt52_decoder_pkg.sv | 50 +++++
 rtl/vt52_fill.sv | 59 +++++
 rtl/vt52_decoder.sv | 242 ++++++++++++++++++++++++
 tb/tb_vt52_decoder.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vt52_decoder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vt52_decoder_pkg : shared constants, state encoding and coordinate helper
// Rev 1.0
// ----------------------------------------------------------------------------
package vt52_decoder_pkg;

  localparam int C_COLS_DEF = 80;
  localparam int C_ROWS_DEF = 25;
  localparam int C_TAB_DEF  = 8;

  localparam logic [7:0] c_BS    = 8'h08;
  localparam logic [7:0] c_HT    = 8'h09;
  localparam logic [7:0] c_LF    = 8'h0A;
  localparam logic [7:0] c_CR    = 8'h0D;
  localparam logic [7:0] c_ESC   = 8'h1B;
  localparam logic [7:0] c_SPACE = 8'h20;
  localparam logic [7:0] c_TILDE = 8'h7E;

  localparam logic [7:0] c_CMD_UP    = 8'h41;  // 'A'
  localparam logic [7:0] c_CMD_DOWN  = 8'h42;  // 'B'
  localparam logic [7:0] c_CMD_RIGHT = 8'h43;  // 'C'
  localparam logic [7:0] c_CMD_LEFT  = 8'h44;  // 'D'
  localparam logic [7:0] c_CMD_HOME  = 8'h48;  // 'H'
  localparam logic [7:0] c_CMD_CLR_S = 8'h4A;  // 'J'
  localparam logic [7:0] c_CMD_CLR_L = 8'h4B;  // 'K'
  localparam logic [7:0] c_CMD_ADDR  = 8'h59;  // 'Y'

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_ESC   = 5'b00010,
    ST_Y_ROW = 5'b00100,
    ST_Y_COL = 5'b01000,
    ST_FILL  = 5'b10000
  } state_t;

  // Direct-address byte to coordinate: offset by 0x20, floored at 0, capped at lim.
  function automatic logic [7:0] clamp_coord(input logic [7:0] b, input logic [7:0] lim);
    logic [7:0] v;
    if (b < c_SPACE)
      v = 8'd0;
    else if ((b - c_SPACE) > lim)
      v = lim;
    else
      v = b - c_SPACE;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vt52_fill.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vt52_fill : row-major blank-fill sequencer, one cell per cycle up to (COLS-1, end row)
// Rev 1.0
// ----------------------------------------------------------------------------
module vt52_fill #(
  parameter int COLS = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [6:0] i_start_col,
  input  logic [4:0] i_start_row,
  input  logic [4:0] i_end_row,
  output logic       o_wr,
  output logic [6:0] o_col,
  output logic [4:0] o_row,
  output logic       o_last
);

  localparam logic [6:0] c_LAST_COL = 7'(COLS - 1);

  logic       r_busy;
  logic [6:0] r_col;
  logic [4:0] r_row;
  logic [4:0] r_end_row;
  logic       w_at_eol;

  assign w_at_eol = (r_col == c_LAST_COL);
  assign o_last   = r_busy && w_at_eol && (r_row == r_end_row);
  assign o_wr     = r_busy;
  assign o_col    = r_col;
  assign o_row    = r_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
      r_end_row <= '0;
    end else if (i_start) begin
      r_busy    <= 1'b1;
      r_col     <= i_start_col;
      r_row     <= i_start_row;
      r_end_row <= i_end_row;
    end else if (r_busy) begin
      if (o_last) begin
        r_busy <= 1'b0;
      end else if (w_at_eol) begin
        r_col <= '0;
        r_row <= r_row + 5'd1;
      end else begin
        r_col <= r_col + 7'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vt52_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vt52_decoder : VT52 byte-stream parser driving a character-cell write port and cursor
// Rev 1.0
// ----------------------------------------------------------------------------
module vt52_decoder
  import vt52_decoder_pkg::*;
#(
  parameter int COLS = C_COLS_DEF,
  parameter int ROWS = C_ROWS_DEF,
  parameter int TAB  = C_TAB_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       wr,
  output logic [6:0] wr_col,
  output logic [4:0] wr_row,
  output logic [7:0] wr_char,
  output logic       scroll,
  output logic [6:0] cur_col,
  output logic [4:0] cur_row
);

  localparam logic [6:0] c_LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] c_LAST_ROW = 5'(ROWS - 1);
  localparam logic [7:0] c_TAB_MASK = 8'(TAB - 1);

  state_t     r_state, w_state_n;
  logic [6:0] r_col, w_col_n;
  logic [4:0] r_row, w_row_n;
  logic [4:0] r_y_row, w_y_row_n;
  logic       r_wr, w_wr_n;
  logic [6:0] r_wr_col, w_wr_col_n;
  logic [4:0] r_wr_row, w_wr_row_n;
  logic [7:0] r_wr_char, w_wr_char_n;
  logic       r_scroll, w_scroll_n;
  logic       r_scroll_pend, w_scroll_pend_n;
  logic       r_start_pend, w_start_pend_n;
  logic       r_ready;

  logic       w_xfer;
  logic       w_printable;
  logic [7:0] w_tab_next;
  logic [6:0] w_tab_col;
  logic [4:0] w_byte_row;
  logic [6:0] w_byte_col;

  logic       w_fill_start;
  logic [6:0] w_fill_col0;
  logic [4:0] w_fill_row0;
  logic [4:0] w_fill_row_end;
  logic       w_fill_wr;
  logic [6:0] w_fill_col;
  logic [4:0] w_fill_row;
  logic       w_fill_last;

  assign w_xfer      = valid && r_ready;
  assign w_printable = (data >= c_SPACE) && (data <= c_TILDE);
  assign w_tab_next  = ({1'b0, r_col} | c_TAB_MASK) + 8'd1;
  assign w_tab_col   = (w_tab_next > {1'b0, c_LAST_COL}) ? c_LAST_COL : w_tab_next[6:0];
  assign w_byte_row  = 5'(clamp_coord(data, 8'(ROWS - 1)));
  assign w_byte_col  = 7'(clamp_coord(data, 8'(COLS - 1)));

  always_comb begin
    w_state_n       = r_state;
    w_col_n         = r_col;
    w_row_n         = r_row;
    w_y_row_n       = r_y_row;
    w_wr_n          = 1'b0;
    w_wr_col_n      = r_wr_col;
    w_wr_row_n      = r_wr_row;
    w_wr_char_n     = r_wr_char;
    w_scroll_n      = 1'b0;
    w_scroll_pend_n = 1'b0;
    w_start_pend_n  = 1'b0;
    w_fill_start    = 1'b0;
    w_fill_col0     = r_col;
    w_fill_row0     = r_row;
    w_fill_row_end  = r_row;

    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          if (w_printable) begin
            w_wr_n      = 1'b1;
            w_wr_col_n  = r_col;
            w_wr_row_n  = r_row;
            w_wr_char_n = data;
            if (r_col == c_LAST_COL) begin
              w_col_n = '0;
              // Wrap on the bottom row: scroll must wait a cycle so it never coincides with wr.
              if (r_row == c_LAST_ROW) begin
                w_scroll_pend_n = 1'b1;
                w_state_n       = ST_FILL;
              end else begin
                w_row_n = r_row + 5'd1;
              end
            end else begin
              w_col_n = r_col + 7'd1;
            end
          end else begin
            case (data)
              c_CR:  w_col_n = '0;
              c_LF: begin
                if (r_row == c_LAST_ROW) begin
                  w_scroll_n     = 1'b1;
                  w_start_pend_n = 1'b1;
                  w_state_n      = ST_FILL;
                end else begin
                  w_row_n = r_row + 5'd1;
                end
              end
              c_BS:  if (r_col != '0) w_col_n = r_col - 7'd1;
              c_HT:  w_col_n = w_tab_col;
              c_ESC: w_state_n = ST_ESC;
              default: ;
            endcase
          end
        end
      end

      ST_ESC: begin
        if (w_xfer) begin
          w_state_n = ST_IDLE;
          case (data)
            c_CMD_UP:    if (r_row != '0) w_row_n = r_row - 5'd1;
            c_CMD_DOWN:  if (r_row != c_LAST_ROW) w_row_n = r_row + 5'd1;
            c_CMD_RIGHT: if (r_col != c_LAST_COL) w_col_n = r_col + 7'd1;
            c_CMD_LEFT:  if (r_col != '0) w_col_n = r_col - 7'd1;
            c_CMD_HOME: begin
              w_col_n = '0;
              w_row_n = '0;
            end
            c_CMD_CLR_S: begin
              w_fill_start   = 1'b1;
              w_fill_row_end = c_LAST_ROW;
              w_state_n      = ST_FILL;
            end
            c_CMD_CLR_L: begin
              w_fill_start = 1'b1;
              w_state_n    = ST_FILL;
            end
            c_CMD_ADDR: w_state_n = ST_Y_ROW;
            c_ESC:      w_state_n = ST_ESC;
            default: ;
          endcase
        end
      end

      ST_Y_ROW: begin
        if (w_xfer) begin
          w_y_row_n = w_byte_row;
          w_state_n = ST_Y_COL;
        end
      end

      ST_Y_COL: begin
        if (w_xfer) begin
          w_col_n   = w_byte_col;
          w_row_n   = r_y_row;
          w_state_n = ST_IDLE;
        end
      end

      ST_FILL: begin
        if (r_scroll_pend) begin
          w_scroll_n     = 1'b1;
          w_start_pend_n = 1'b1;
        end else if (r_start_pend) begin
          w_fill_start   = 1'b1;
          w_fill_col0    = '0;
          w_fill_row0    = c_LAST_ROW;
          w_fill_row_end = c_LAST_ROW;
        end else if (w_fill_last) begin
          w_state_n = ST_IDLE;
        end
      end

      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_col         <= '0;
      r_row         <= '0;
      r_y_row       <= '0;
      r_wr          <= 1'b0;
      r_wr_col      <= '0;
      r_wr_row      <= '0;
      r_wr_char     <= '0;
      r_scroll      <= 1'b0;
      r_scroll_pend <= 1'b0;
      r_start_pend  <= 1'b0;
      r_ready       <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_col         <= w_col_n;
      r_row         <= w_row_n;
      r_y_row       <= w_y_row_n;
      r_wr          <= w_wr_n;
      r_wr_col      <= w_wr_col_n;
      r_wr_row      <= w_wr_row_n;
      r_wr_char     <= w_wr_char_n;
      r_scroll      <= w_scroll_n;
      r_scroll_pend <= w_scroll_pend_n;
      r_start_pend  <= w_start_pend_n;
      r_ready       <= (w_state_n != ST_FILL);
    end
  end

  vt52_fill #(
    .COLS(COLS)
  ) u_fill (
    .clk         (clk),
    .rst         (reset),
    .i_start     (w_fill_start),
    .i_start_col (w_fill_col0),
    .i_start_row (w_fill_row0),
    .i_end_row   (w_fill_row_end),
    .o_wr        (w_fill_wr),
    .o_col       (w_fill_col),
    .o_row       (w_fill_row),
    .o_last      (w_fill_last)
  );

  // Character writes and fill writes are never active in the same cycle.
  assign wr      = r_wr | w_fill_wr;
  assign wr_col  = w_fill_wr ? w_fill_col : r_wr_col;
  assign wr_row  = w_fill_wr ? w_fill_row : r_wr_row;
  assign wr_char = w_fill_wr ? c_SPACE : r_wr_char;
  assign scroll  = r_scroll;
  assign ready   = r_ready;
  assign cur_col = r_col;
  assign cur_row = r_row;

endmodule
`default_nettype wire

// File: tb/tb_vt52_decoder.sv
`default_nettype none
// Bench for vt52_decoder: vector table, multi-cycle timing sequences, and a random
// byte stream checked against a cell-level screen model.
module tb_vt52_decoder;

  localparam int COLS = 80;
  localparam int ROWS = 25;
  localparam int TAB  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, wr, scroll;
  logic [6:0] wr_col, cur_col;
  logic [4:0] wr_row, cur_row;
  logic [7:0] wr_char;

  vt52_decoder #(.COLS(COLS), .ROWS(ROWS), .TAB(TAB)) dut (
    .clk(clk), .reset(reset), .data(data), .valid(valid), .ready(ready),
    .wr(wr), .wr_col(wr_col), .wr_row(wr_row), .wr_char(wr_char),
    .scroll(scroll), .cur_col(cur_col), .cur_row(cur_row)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Event word: {scroll, col[6:0], row[4:0], char[7:0]}
  logic [20:0] exp_q[$];
  logic [20:0] act_q[$];
  int          n_wr = 0;
  logic        overlap_seen = 1'b0;

  int m_col = 0, m_row = 0, m_y = 0, m_st = 0;  // m_st: 0 idle, 1 esc, 2 row, 3 col

  typedef struct {
    logic [7:0] b;
    int         col;
    int         row;
    int         nwr;
  } vec_t;
  vec_t tbl[$];

  always @(negedge clk) begin
    if (wr) begin
      act_q.push_back({1'b0, wr_col, wr_row, wr_char});
      n_wr++;
    end
    if (scroll) act_q.push_back(21'h100000);
    if (wr && scroll) overlap_seen = 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_wr(input int c, input int r, input logic [7:0] ch);
    exp_q.push_back({1'b0, 7'(c), 5'(r), ch});
  endtask

  task automatic model_fill(input int sc, input int sr, input int er);
    for (int r = sr; r <= er; r++)
      for (int c = (r == sr) ? sc : 0; c < COLS; c++)
        push_wr(c, r, 8'h20);
  endtask

  task automatic model_lf();
    if (m_row == ROWS - 1) begin
      exp_q.push_back(21'h100000);
      model_fill(0, ROWS - 1, ROWS - 1);
    end else begin
      m_row++;
    end
  endtask

  function automatic int coord(input logic [7:0] b, input int lim);
    int v;
    v = int'(b) - 32;
    if (v < 0) return 0;
    if (v > lim - 1) return lim - 1;
    return v;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    case (m_st)
      0: begin
        if (b >= 8'h20 && b <= 8'h7E) begin
          push_wr(m_col, m_row, b);
          if (m_col == COLS - 1) begin
            m_col = 0;
            model_lf();
          end else begin
            m_col++;
          end
        end else if (b == 8'h0D) m_col = 0;
        else if (b == 8'h0A) model_lf();
        else if (b == 8'h08) begin if (m_col > 0) m_col--; end
        else if (b == 8'h09) begin
          m_col = ((m_col / TAB) + 1) * TAB;
          if (m_col > COLS - 1) m_col = COLS - 1;
        end else if (b == 8'h1B) m_st = 1;
      end
      1: begin
        m_st = 0;
        case (b)
          8'h41: if (m_row > 0) m_row--;
          8'h42: if (m_row < ROWS - 1) m_row++;
          8'h43: if (m_col < COLS - 1) m_col++;
          8'h44: if (m_col > 0) m_col--;
          8'h48: begin m_col = 0; m_row = 0; end
          8'h4A: model_fill(m_col, m_row, ROWS - 1);
          8'h4B: model_fill(m_col, m_row, m_row);
          8'h59: m_st = 2;
          8'h1B: m_st = 1;
          default: ;
        endcase
      end
      2: begin
        m_y  = coord(b, ROWS);
        m_st = 3;
      end
      default: begin
        m_col = coord(b, COLS);
        m_row = m_y;
        m_st  = 0;
      end
    endcase
  endtask

  // ---------------- drivers / checkers (called at a falling edge) ----------------
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!ready && n < 3000) begin @(negedge clk); n++; end
    if (!ready) chk("send_ready_timeout", 0, 1);
    data  = b;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic check_events();
    int na, ne;
    na = act_q.size();
    ne = exp_q.size();
    chk("event_count", na, ne);
    for (int i = 0; i < na && i < ne; i++) begin
      vectors++;
      if (act_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL event[%0d]: got scroll=%0b col=%0d row=%0d char=%02h, expected scroll=%0b col=%0d row=%0d char=%02h",
                 i, act_q[i][20], act_q[i][19:13], act_q[i][12:8], act_q[i][7:0],
                 exp_q[i][20], exp_q[i][19:13], exp_q[i][12:8], exp_q[i][7:0]);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic settle();
    int n = 0;
    while (!ready && n < 3000) begin @(negedge clk); n++; end
    if (!ready) chk("settle_ready_timeout", 0, 1);
    #1;
    check_events();
    chk("cur_col", cur_col, m_col);
    chk("cur_row", cur_row, m_row);
    chk("wr_scroll_exclusive", overlap_seen, 0);
  endtask

  task automatic apply(input logic [7:0] b);
    model_byte(b);
    send(b);
    settle();
  endtask

  task automatic add(input logic [7:0] b, input int c, input int r, input int n);
    vec_t v;
    v.b = b; v.col = c; v.row = r; v.nwr = n;
    tbl.push_back(v);
  endtask

  function automatic logic [7:0] rand_byte();
    int k;
    k = $urandom_range(0, 99);
    if (k < 40) return 8'($urandom_range(32, 126));
    if (k < 55) begin
      case ($urandom_range(0, 3))
        0: return 8'h0D;
        1: return 8'h0A;
        2: return 8'h08;
        default: return 8'h09;
      endcase
    end
    if (k < 65) return 8'h1B;
    if (k < 80) begin
      case ($urandom_range(0, 7))
        0: return 8'h41;
        1: return 8'h42;
        2: return 8'h43;
        3: return 8'h44;
        4: return 8'h48;
        5: return 8'h4A;
        6: return 8'h4B;
        default: return 8'h59;
      endcase
    end
    if (k < 90) return 8'($urandom_range(32, 64));
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int snap, n;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_wr", wr, 0);
    chk("rst_scroll", scroll, 0);
    chk("rst_wr_col", wr_col, 0);
    chk("rst_wr_row", wr_row, 0);
    chk("rst_wr_char", wr_char, 0);
    chk("rst_cur_col", cur_col, 0);
    chk("rst_cur_row", cur_row, 0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_after_reset", ready, 1);
    @(negedge clk);

    // Vector table: byte, expected cursor after it, expected wr pulses
    add(8'h41, 1, 0, 1);  add(8'h42, 2, 0, 1);
    add(8'h1B, 2, 0, 0);  add(8'h59, 2, 0, 0);  add(8'h25, 2, 0, 0);  add(8'h2A, 10, 5, 0);
    add(8'h1B, 10, 5, 0); add(8'h59, 10, 5, 0); add(8'h7F, 10, 5, 0); add(8'h7F, 79, 24, 0);
    add(8'h0D, 0, 24, 0); add(8'h08, 0, 24, 0);
    add(8'h1B, 0, 24, 0); add(8'h48, 0, 0, 0);
    add(8'h1B, 0, 0, 0);  add(8'h41, 0, 0, 0);
    add(8'h1B, 0, 0, 0);  add(8'h51, 0, 0, 0);
    add(8'h1B, 0, 0, 0);  add(8'h44, 0, 0, 0);
    add(8'h09, 8, 0, 0);  add(8'h09, 16, 0, 0);
    add(8'h1B, 16, 0, 0); add(8'h59, 16, 0, 0); add(8'h20, 16, 0, 0); add(8'h6E, 78, 0, 0);
    add(8'h09, 79, 0, 0); add(8'h5A, 0, 1, 1);  add(8'h7F, 0, 1, 0);  add(8'h0A, 0, 2, 0);
    add(8'h1B, 0, 2, 0);  add(8'h43, 1, 2, 0);  add(8'h1B, 1, 2, 0);  add(8'h42, 1, 3, 0);
    add(8'h1B, 1, 3, 0);  add(8'h1B, 1, 3, 0);  add(8'h43, 2, 3, 0);
    add(8'h1B, 2, 3, 0);  add(8'h59, 2, 3, 0);  add(8'h10, 2, 3, 0);  add(8'h10, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      snap = n_wr;
      apply(tbl[i].b);
      chk($sformatf("tbl[%0d]_col", i), cur_col, tbl[i].col);
      chk($sformatf("tbl[%0d]_row", i), cur_row, tbl[i].row);
      chk($sformatf("tbl[%0d]_nwr", i), n_wr - snap, tbl[i].nwr);
      chk($sformatf("tbl[%0d]_ready", i), ready, 1);
    end

    // ESC K at (78,3): two blank writes with ready low, cursor unchanged
    apply(8'h1B); apply(8'h59); apply(8'h23); apply(8'h6E);
    apply(8'h1B);
    model_byte(8'h4B);
    send(8'h4B);
    #1;
    chk("k_c1_ready", ready, 0);
    chk("k_c1_wr", wr, 1);
    chk("k_c1_col", wr_col, 78);
    chk("k_c1_row", wr_row, 3);
    chk("k_c1_char", wr_char, 8'h20);
    @(negedge clk); #1;
    chk("k_c2_ready", ready, 0);
    chk("k_c2_col", wr_col, 79);
    @(negedge clk); #1;
    chk("k_c3_ready", ready, 1);
    chk("k_c3_wr", wr, 0);
    settle();

    // LF on the bottom row at (5,24): scroll, then 80 blanks on row 24
    apply(8'h1B); apply(8'h59); apply(8'h38); apply(8'h25);
    model_byte(8'h0A);
    send(8'h0A);
    #1;
    chk("lf_c1_scroll", scroll, 1);
    chk("lf_c1_wr", wr, 0);
    chk("lf_c1_ready", ready, 0);
    @(negedge clk); #1;
    chk("lf_c2_wr", wr, 1);
    chk("lf_c2_scroll", scroll, 0);
    chk("lf_c2_col", wr_col, 0);
    chk("lf_c2_row", wr_row, 24);
    n = 2;
    while (!ready && n < 300) begin @(negedge clk); n++; end
    chk("lf_ready_return_cycle", n, 82);
    settle();

    // Line wrap at (79,24): char, then scroll, then the fill
    apply(8'h1B); apply(8'h59); apply(8'h38); apply(8'h6F);
    model_byte(8'h78);
    send(8'h78);
    #1;
    chk("wrap_c1_wr", wr, 1);
    chk("wrap_c1_char", wr_char, 8'h78);
    chk("wrap_c1_scroll", scroll, 0);
    @(negedge clk); #1;
    chk("wrap_c2_scroll", scroll, 1);
    chk("wrap_c2_wr", wr, 0);
    @(negedge clk); #1;
    chk("wrap_c3_wr", wr, 1);
    chk("wrap_c3_col", wr_col, 0);
    settle();

    // Reset 10 cycles into ESC J at (0,0)
    apply(8'h1B); apply(8'h48);
    send(8'h1B);
    send(8'h4A);
    repeat (9) @(negedge clk);
    #1;
    chk("rj_filling", wr, 1);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("rj_wr", wr, 0);
    chk("rj_ready", ready, 0);
    chk("rj_cur_col", cur_col, 0);
    chk("rj_cur_row", cur_row, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("rj_ready_after", ready, 1);
    act_q.delete();
    exp_q.delete();
    m_col = 0; m_row = 0; m_y = 0; m_st = 0;
    @(negedge clk);

    // Randomized stream against the model
    for (int i = 0; i < 300; i++) apply(rand_byte());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
